// File: rtl/chunked_addsub.sv
`timescale 1ns/1ps
// chunked_addsub: N-bit add/subtract reusing one W-bit ripple slice, least-significant chunk first.
// Latency: N/W cycles from the accepted start edge to the one-cycle done pulse.
// Backpressure: start is accepted only while idle; a start while busy is dropped, never queued.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 operation request, sampled only when busy == 0
//   input1, input2        operands A and B (N bits), captured on an accepted start
//   carry_in, sub         carry into bit 0 (add only) and subtract select, captured on start
//   busy                  high while chunks are being processed
//   done                  one-cycle pulse when answer/carry_out/overflow are updated
//   answer                N-bit result, held until the next completion
//   carry_out, overflow   carry out of bit N-1 (1 = no borrow on subtract), signed overflow
module chunked_addsub #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         carry_in,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] answer,
  output logic         carry_out,
  output logic         overflow
);

  localparam int CYCLES = N / W;
  localparam int KW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;        // effective B: already inverted for subtract
  logic [N-1:0]  result;
  logic          carry_reg;
  logic [KW-1:0] k;

  logic          accept;
  logic          last;
  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W:0]    sum;
  logic [N-1:0]  result_full;

  always_comb begin
    accept = (state == IDLE) && start;
    last   = (state == RUN) && (k == K_LAST);
  end

  // The single shared W-bit slice.
  always_comb begin
    a_chunk = a_reg[k*W +: W];
    b_chunk = b_reg[k*W +: W];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry_reg};
  end

  // Result with the current chunk merged in, so the final edge can publish
  // the complete value without waiting a cycle for the result register.
  always_comb begin
    result_full              = result;
    result_full[k*W +: W]    = sum[W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
      done      <= 1'b0;
      answer    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg     <= input1;
        // Subtract is A + ~B + 1; carry_in is irrelevant in that case.
        b_reg     <= sub ? ~input2 : input2;
        carry_reg <= sub | carry_in;
        k         <= '0;
        result    <= '0;
      end else if (state == RUN) begin
        result    <= result_full;
        carry_reg <= sum[W];
        k         <= last ? '0 : k + 1'b1;
        if (last) begin
          answer    <= result_full;
          carry_out <= sum[W];
          // Operands of equal sign producing a result of the other sign.
          overflow  <= (a_reg[N-1] == b_reg[N-1]) && (result_full[N-1] != a_reg[N-1]);
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
`timescale 1ns/1ps
// tb_chunked_addsub: directed checks of chunked_addsub at W = 1, 8 and 32 with N = 32.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic        carry_in = 1'b0;
  logic        sub = 1'b0;

  // Instance 0: W=1, instance 1: W=8 (main), instance 2: W=32.
  logic        start_w   [3];
  logic        busy_w    [3];
  logic        done_w    [3];
  logic [31:0] ans_w     [3];
  logic        cout_w    [3];
  logic        ovf_w     [3];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WG = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    chunked_addsub #(.N(32), .W(WG)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_w[g]),
      .input1    (input1),
      .input2    (input2),
      .carry_in  (carry_in),
      .sub       (sub),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .answer    (ans_w[g]),
      .carry_out (cout_w[g]),
      .overflow  (ovf_w[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until done is seen on instance i; bounded so a dead DUT cannot hang the run.
  task automatic wait_done(input int i, output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (done_w[i] !== 1'b1 && n < 200) begin
      if (busy_w[i] === 1'b1) busy_cycles++;
      tick();
      n++;
    end
  endtask

  // One complete operation on instance i with full timing and result checks.
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic s,
                        input logic [31:0] ea, input logic ec, input logic eo,
                        input string tag);
    int n;
    int bc;
    int lat;
    lat = (i == 0) ? 32 : ((i == 1) ? 4 : 1);
    input1 = a; input2 = b; carry_in = cin; sub = s;
    start_w[i] = 1'b1;
    tick();
    start_w[i] = 1'b0;
    wait_done(i, n, bc);
    chkn({tag, "_latency"}, n, lat);
    chkn({tag, "_busy_cycles"}, bc, lat);
    chk1({tag, "_busy_at_done"}, busy_w[i], 1'b0);
    chk32({tag, "_answer"}, ans_w[i], ea);
    chk1({tag, "_carry_out"}, cout_w[i], ec);
    chk1({tag, "_overflow"}, ovf_w[i], eo);
    tick();
    chk1({tag, "_done_one_cycle"}, done_w[i], 1'b0);
  endtask

  initial begin
    int n;
    int bc;
    logic done_seen;
    logic [31:0] ra, rb, beff;
    logic rcin, rs, ci;
    logic [32:0] r;

    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;

    // Reset state.
    tick();
    tick();
    chk1("rst_busy", busy_w[1], 1'b0);
    chk1("rst_done", done_w[1], 1'b0);
    chk32("rst_answer", ans_w[1], 32'h0);
    chk1("rst_carry_out", cout_w[1], 1'b0);
    chk1("rst_overflow", ovf_w[1], 1'b0);
    rst = 1'b0;
    tick();

    // Directed arithmetic on the W=8 instance.
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
    run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    run_op(1, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_cin");
    run_op(1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
    run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    run_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_cin_ignored");
    run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_cin_ignored2");

    // start held high: the done cycle is idle, so the held start is taken there.
    input1 = 32'd1; input2 = 32'd2; carry_in = 1'b0; sub = 1'b0;
    start_w[1] = 1'b1;
    tick();
    wait_done(1, n, bc);
    chkn("hold_latency1", n, 4);
    chk32("hold_answer1", ans_w[1], 32'd3);
    input1 = 32'd10; input2 = 32'd20;
    tick();
    chk1("hold_accepted", busy_w[1], 1'b1);
    chk32("hold_answer_kept", ans_w[1], 32'd3);
    start_w[1] = 1'b0;
    wait_done(1, n, bc);
    chkn("hold_latency2", n, 4);
    chk32("hold_answer2", ans_w[1], 32'd30);
    tick();

    // start pulse while busy, with different operands, must be ignored.
    input1 = 32'd100; input2 = 32'd23;
    start_w[1] = 1'b1;
    tick();
    start_w[1] = 1'b0;
    tick();
    input1 = 32'hAAAA_AAAA; input2 = 32'h5555_5555; sub = 1'b1; carry_in = 1'b1;
    start_w[1] = 1'b1;
    tick();
    start_w[1] = 1'b0;
    chk32("run_answer_held", ans_w[1], 32'd30);
    wait_done(1, n, bc);
    chkn("ignore_latency", n, 2);
    chk32("ignore_answer", ans_w[1], 32'd123);
    chk1("ignore_carry_out", cout_w[1], 1'b0);
    tick();
    chk1("ignore_no_queue", busy_w[1], 1'b0);
    sub = 1'b0; carry_in = 1'b0;

    // Produce nonzero carry_out/overflow so the reset check below is meaningful.
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "pre_reset");

    // Reset in cycle 2 of a RUN.
    input1 = 32'd5; input2 = 32'd6;
    start_w[1] = 1'b1;
    tick();
    start_w[1] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("midrst_busy", busy_w[1], 1'b0);
    chk1("midrst_done", done_w[1], 1'b0);
    chk32("midrst_answer", ans_w[1], 32'h0);
    chk1("midrst_carry_out", cout_w[1], 1'b0);
    chk1("midrst_overflow", ovf_w[1], 1'b0);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      done_seen = done_seen | done_w[1];
    end
    chk1("midrst_no_done", done_seen, 1'b0);
    run_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_reset");

    // Width sweep: random operands against a full-width reference.
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 4; t++) begin
        ra = $urandom;
        rb = $urandom;
        rcin = 1'($urandom_range(1));
        rs = 1'($urandom_range(1));
        if (t == 0) begin
          ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; rcin = 1'b0; rs = 1'b0;
        end
        beff = rs ? ~rb : rb;
        ci = rs ? 1'b1 : rcin;
        r = {1'b0, ra} + {1'b0, beff} + {32'h0, ci};
        run_op(i, ra, rb, rcin, rs, r[31:0], r[32],
               (ra[31] == beff[31]) && (r[31] != ra[31]),
               $sformatf("sweep_w%0d_%0d", (i == 0) ? 1 : ((i == 1) ? 8 : 32), t));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
